// File: rtl/pc_sequencer.sv
// Next-PC controller for the MIPS fetch path: sequential/branch/jump selection,
// imem handshake, stall hold and deferred redirects. Define PC_SEQ_PERF_EN for perf counters.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic        instr_valid,
    output logic        align_err
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } state_t;

    state_t      state;
    logic        req_q;
    logic        pend_valid;
    logic [31:0] pend_target;

    logic        advance;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        apply_redirect;
    logic [31:0] apply_target;

    // Next-PC selection; a latched redirect outranks anything arriving this cycle.
    always_comb begin
        advance         = 1'b0;
        redirect        = jump | branch_taken;
        redirect_target = jump ? jump_target : branch_target;
        apply_redirect  = pend_valid | redirect;
        apply_target    = pend_valid ? pend_target : redirect_target;
        pc_next         = pc_cur;
        align_err       = 1'b0;

        case (state)
            FETCH:   advance = imem_ready & ~stall;
            HOLD:    advance = ~stall;
            default: advance = 1'b0;
        endcase

        if (state == BOOT) begin
            pc_next = RESET_PC;
        end else if (advance) begin
            if (apply_redirect) begin
                pc_next   = {apply_target[31:2], 2'b00};
                align_err = |apply_target[1:0];
            end else begin
                pc_next = pc_cur + STEP;
            end
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_cur;
    assign instr_valid = (state == FETCH) & imem_ready & ~pend_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
            req_q <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready && stall) begin
                        state <= HOLD;
                        req_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state <= FETCH;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= BOOT;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // The raw target is kept so misalignment can still be flagged when it is applied.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
        end else if (state != BOOT) begin
            if (advance) begin
                pend_valid <= 1'b0;
            end else if (redirect) begin
                pend_valid  <= 1'b1;
                pend_target <= redirect_target;
            end
        end
    end

`ifdef PC_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (instr_valid)
                fetch_cnt <= fetch_cnt + 32'h1;
            if ((state == HOLD) || (state == FETCH && !imem_ready))
                stall_cnt <= stall_cnt + 32'h1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the fetch rules.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_reg = 32'h0;
    logic [31:0] pc_next;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        instr_valid;
    logic        align_err;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    pc_sequencer #(
        .RESET_PC(RST_PC),
        .PC_STEP (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_cur       (pc_reg),
        .pc_next      (pc_next),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .instr_valid  (instr_valid),
        .align_err    (align_err)
`ifdef PC_SEQ_PERF_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: "started" after the boot cycle, "waiting" while the
    // downstream stall holds the pipe, and at most one deferred redirect.
    bit          m_started;
    bit          m_waiting;
    logic [31:0] m_deferred[$];
    logic [31:0] m_fetches;
    logic [31:0] m_stalls;

    logic [31:0] e_next;
    logic        e_req, e_iv, e_ae, e_moves;
    logic [31:0] o_addr;
    logic        o_req, o_iv, o_ae;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_started = 1'b0;
        m_waiting = 1'b0;
        m_deferred.delete();
        m_fetches = 32'h0;
        m_stalls  = 32'h0;
        pc_reg    = 32'h0;
    endtask

    task automatic predict();
        logic [31:0] dest;
        bit          is_redirect;
        e_next = pc_reg; e_req = 1'b0; e_iv = 1'b0; e_ae = 1'b0; e_moves = 1'b0;
        if (!m_started) begin
            e_next = RST_PC;
        end else begin
            e_req   = !m_waiting;
            e_moves = m_waiting ? !stall : (imem_ready && !stall);
            e_iv    = !m_waiting && imem_ready && (m_deferred.size() == 0);
            if (e_moves) begin
                is_redirect = 1'b1;
                if (m_deferred.size() != 0) dest = m_deferred[0];
                else if (jump)              dest = jump_target;
                else if (branch_taken)      dest = branch_target;
                else begin
                    is_redirect = 1'b0;
                    dest = pc_reg + 32'd4;
                end
                if (is_redirect) begin
                    e_ae   = (dest % 4) != 0;
                    e_next = dest - (dest % 4);
                end else begin
                    e_next = dest;
                end
            end
        end
    endtask

    task automatic modelAdvance();
        if (!m_started) begin
            m_started = 1'b1;
            m_waiting = 1'b0;
        end else begin
            if (e_iv) m_fetches = m_fetches + 32'h1;
            if (m_waiting || !imem_ready) m_stalls = m_stalls + 32'h1;
            if (e_moves) m_deferred.delete();
            else if (jump || branch_taken) begin
                m_deferred.delete();
                m_deferred.push_back(jump ? jump_target : branch_target);
            end
            if (!m_waiting && imem_ready && stall) m_waiting = 1'b1;
            else if (m_waiting && !stall)          m_waiting = 1'b0;
        end
        pc_reg = e_next;
    endtask

    // One clock cycle: drive, check mid-cycle against the model, then step the model.
    task automatic applyStimulus(input logic s, input logic br, input logic [31:0] bt,
                                 input logic j, input logic [31:0] jt, input logic rdy);
        stall = s; branch_taken = br; branch_target = bt;
        jump = j; jump_target = jt; imem_ready = rdy;
        #4;
        predict();
        o_addr = imem_addr; o_req = imem_req; o_iv = instr_valid; o_ae = align_err;
        checkOutput("pc_next", pc_next, e_next);
        checkOutput("imem_req", {31'h0, imem_req}, {31'h0, e_req});
        checkOutput("imem_addr", imem_addr, pc_reg);
        checkOutput("instr_valid", {31'h0, instr_valid}, {31'h0, e_iv});
        checkOutput("align_err", {31'h0, align_err}, {31'h0, e_ae});
`ifdef PC_SEQ_PERF_EN
        checkOutput("fetch_cnt", fetch_cnt, m_fetches);
        checkOutput("stall_cnt", stall_cnt, m_stalls);
`endif
        @(posedge clk);
        #1;
        if (rst) modelAdvance();
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        modelReset();
        @(posedge clk);
        #1;
        idle(1'b1);
        idle(1'b1);
        rst = 1'b1;

        // Boot then three sequential fetches from RESET_PC.
        idle(1'b1);
        checkOutput("boot_req", {31'h0, o_req}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            checkOutput("seq_addr", o_addr, RST_PC + 32'(4 * i));
            checkOutput("seq_valid", {31'h0, o_iv}, 32'h1);
        end

        // Jump beats branch in the same advancing cycle.
        applyStimulus(1'b0, 1'b1, 32'h50, 1'b1, 32'h100, 1'b1);
        idle(1'b1);
        checkOutput("jump_prio_addr", o_addr, 32'h100);

        // Branch during a 3-cycle wait is deferred; the completing word is suppressed.
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        checkOutput("wait_hold_addr", o_addr, 32'h104);
        idle(1'b1);
        checkOutput("wrong_path_valid", {31'h0, o_iv}, 32'h0);
        idle(1'b1);
        checkOutput("deferred_addr", o_addr, 32'h200);

        // Stall coinciding with ready at PC 0x10.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            checkOutput("hold_req", {31'h0, o_req}, 32'h0);
            checkOutput("hold_addr", o_addr, 32'h10);
        end
        idle(1'b1);
        idle(1'b1);
        checkOutput("after_hold_addr", o_addr, 32'h14);

        // Unaligned jump target, then sequential wrap at the top of memory.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h103, 1'b1);
        checkOutput("align_err_pulse", {31'h0, o_ae}, 32'h1);
        idle(1'b1);
        checkOutput("aligned_addr", o_addr, 32'h100);
        checkOutput("align_err_clear", {31'h0, o_ae}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        idle(1'b1);
        checkOutput("top_addr", o_addr, 32'hFFFF_FFFC);
        idle(1'b1);
        checkOutput("wrap_addr", o_addr, 32'h0);

        // Reset asserted mid-HOLD with a redirect pending.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
        stall = 1'b1; imem_ready = 1'b1; branch_taken = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
        checkOutput("rst_pc_next", pc_next, RST_PC);
        checkOutput("rst_valid", {31'h0, instr_valid}, 32'h0);
`ifdef PC_SEQ_PERF_EN
        checkOutput("rst_fetch_cnt", fetch_cnt, 32'h0);
        checkOutput("rst_stall_cnt", stall_cnt, 32'h0);
`endif
        modelReset();
        @(posedge clk);
        #1;
        idle(1'b1);
        rst = 1'b1;
        idle(1'b1);
        idle(1'b1);
        checkOutput("post_rst_addr", o_addr, RST_PC);
        checkOutput("post_rst_valid", {31'h0, o_iv}, 32'h1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        r_s, r_br, r_j, r_rdy;
            logic [31:0] r_bt, r_jt;
            r_rdy = ($urandom_range(0, 3) != 0);
            r_s   = ($urandom_range(0, 3) == 0);
            r_j   = ($urandom_range(0, 9) == 0);
            r_br  = ($urandom_range(0, 6) == 0);
            r_bt  = $urandom;
            r_jt  = $urandom;
            if ($urandom_range(0, 1) == 0) r_bt[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) r_jt[1:0] = 2'b00;
            applyStimulus(r_s, r_br, r_bt, r_j, r_jt, r_rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
